// File: rtl/discotective_pkg.sv
// Shared types and constants for the binary-image SDRAM write path.
// Holds bus widths, the packer state encoding and the default frame size.
package discotective_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  // 640x480 one-bit pixels packed 16 per word.
  localparam int FRAME_WORDS_DEFAULT = 19200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } packer_state_t;

  // Shift one pixel into a partially built word. LSB-first shifts right and
  // enters at the top, so after 16 pixels the first one sits in bit 0;
  // MSB-first shifts left and enters at the bottom, leaving it in bit 15.
  function automatic logic [DATA_W-1:0] shift_pixel(input logic [DATA_W-1:0] word,
                                                   input logic              pix,
                                                   input logic              msb_first);
    if (msb_first) begin
      shift_pixel = {word[DATA_W-2:0], pix};
    end else begin
      shift_pixel = {pix, word[DATA_W-1:1]};
    end
  endfunction

endpackage

// File: rtl/pixel_write_packer_if.sv
// Pixel input and write-master output bundle for pixel_write_packer.
//
// Handshake: odata/oaddr are valid whenever ovalid=1 and are held stable until
// a rising edge where ovalid=1 and ibusy=0; that edge is the transfer and the
// next word (if any) is presented after it. ibusy acts as an inverted ready.
interface pixel_write_packer_if;
  import discotective_pkg::*;

  // Pixel side
  logic              iframe_start;
  logic [ADDR_W-1:0] ibase_addr;
  logic              ipixel;
  logic              ipixel_valid;

  // Write-master side
  logic              ibusy;
  logic [DATA_W-1:0] odata;
  logic [ADDR_W-1:0] oaddr;
  logic              ovalid;
  logic              oframe_done;
  logic              ooverflow;

  // Current FSM state, for observation only
  packer_state_t     dbg_state;

  modport master (
    input  iframe_start, ibase_addr, ipixel, ipixel_valid, ibusy,
    output odata, oaddr, ovalid, oframe_done, ooverflow, dbg_state
  );

  modport slave (
    output iframe_start, ibase_addr, ipixel, ipixel_valid, ibusy,
    input  odata, oaddr, ovalid, oframe_done, ooverflow, dbg_state
  );

endinterface

// File: rtl/packer_fifo.sv
// Synchronous show-ahead FIFO of {addr,data} entries for the packer.
// A push while full is accepted only if a pop happens on the same edge.
module packer_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     ipush,
  input  logic [WIDTH-1:0]         idata,
  input  logic                     ipop,
  output logic [WIDTH-1:0]         odata,
  output logic                     ofull,
  output logic                     oempty,
  output logic [$clog2(DEPTH):0]   ocount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en;
  logic             rd_en;

  assign oempty = (count_q == '0);
  assign ofull  = (count_q == CW'(DEPTH));
  assign rd_en  = ipop && !oempty;
  assign wr_en  = ipush && (!ofull || rd_en);
  assign odata  = mem_q[rd_ptr_q];
  assign ocount = count_q;

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge iCLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= idata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/pixel_write_packer.sv
// Packs a stream of binarized pixels into 16-bit words and queues each word
// with its SDRAM word address for a downstream write master.
// Optional build macro PACKER_MSB_FIRST_EN: place the first pixel of each word
// in bit 15 instead of bit 0.
// FIFO_DEPTH must be a power of two in the range 2..16.
module pixel_write_packer
  import discotective_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter int FIFO_DEPTH  = 4
) (
  input logic iCLK,
  input logic iRST,
  pixel_write_packer_if.master bus
);

  localparam int WCW = $clog2(FRAME_WORDS + 1);
  localparam int FW  = ADDR_W + DATA_W;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

`ifdef PACKER_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  packer_state_t     state_q;
  logic [3:0]        bit_cnt_q;
  logic [WCW-1:0]    word_cnt_q;
  logic [WCW-1:0]    word_cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              overflow_q;
  logic              frame_done_q;

  logic              pix_take;
  logic              push;
  logic              pop;
  logic              last_pop;
  logic [FW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  // A restart pulse wins over a pixel on the same cycle, so that pixel is lost.
  always_comb begin
    pix_take   = (state_q == PACK) && bus.ipixel_valid && !bus.iframe_start;
    shift_d    = shift_pixel(shift_q, bus.ipixel, MSB_FIRST);
    push       = pix_take && (bit_cnt_q == 4'hF);
    pop        = !fifo_empty && !bus.ibusy;
    last_pop   = (state_q == DONE) && pop && (fifo_count == CW'(1));
    word_cnt_d = word_cnt_q + WCW'(1);
  end

  packer_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .ipush  (push),
    .idata  ({addr_q, shift_d}),
    .ipop   (pop),
    .odata  (head),
    .ofull  (fifo_full),
    .oempty (fifo_empty),
    .ocount (fifo_count)
  );

  // Frame FSM with its counters, address and registered status outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      addr_q       <= '0;
      shift_q      <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_pop;
      if (bus.iframe_start) begin
        // Restart discards the partial word; queued words keep their addresses.
        state_q    <= PACK;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        addr_q     <= bus.ibase_addr;
        if (state_q == IDLE) overflow_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          PACK: begin
            if (pix_take) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (push) begin
                // Address and word count advance even if the word is dropped.
                addr_q     <= addr_q + ADDR_W'(1);
                word_cnt_q <= word_cnt_d;
                if (fifo_full && !pop) overflow_q <= 1'b1;
                if (word_cnt_d == WCW'(FRAME_WORDS)) state_q <= DONE;
              end
            end
          end
          DONE: begin
            if (fifo_empty || last_pop) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ovalid      = !fifo_empty;
  assign bus.odata       = fifo_empty ? '0 : head[DATA_W-1:0];
  assign bus.oaddr       = fifo_empty ? '0 : head[FW-1:DATA_W];
  assign bus.oframe_done = frame_done_q;
  assign bus.ooverflow   = overflow_q;
  assign bus.dbg_state   = state_q;

endmodule
